// File: rtl/alu_pkg.sv
// Opcode map, FSM state encoding and opcode classification for the
// multi-cycle Mips32 ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_BNE   = 5'd11;
    localparam logic [4:0] OP_LUI   = 5'd12;
    localparam logic [4:0] OP_BEQ   = 5'd13;
    localparam logic [4:0] OP_MUL   = 5'd16;
    localparam logic [4:0] OP_MULHU = 5'd17;
    localparam logic [4:0] OP_DIVU  = 5'd18;
    localparam logic [4:0] OP_REMU  = 5'd19;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic logic is_multicycle(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// For multiply hi:lo is the product; for divide hi is the remainder, lo the quotient.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_hi, acc_lo, opb;
    logic             is_div, running;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] src_hi, src_lo, src_b, nxt_hi, nxt_lo;
    logic             src_div;
    logic [WIDTH:0]   sum, shifted;

    // The first step is taken straight from the operands on the start edge, so
    // the remaining WIDTH-1 steps finish one cycle before the FSM leaves BUSY.
    always_comb begin
        src_hi  = start ? '0       : acc_hi;
        src_lo  = start ? a        : acc_lo;
        src_b   = start ? b        : opb;
        src_div = start ? div_mode : is_div;
        sum     = '0;
        shifted = '0;
        nxt_hi  = src_hi;
        nxt_lo  = src_lo;
        if (src_div) begin
            shifted = {src_hi, src_lo[WIDTH-1]};
            if (shifted >= {1'b0, src_b}) begin
                nxt_hi = WIDTH'(shifted - {1'b0, src_b});
                nxt_lo = {src_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = shifted[WIDTH-1:0];
                nxt_lo = {src_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum    = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_b} : {(WIDTH+1){1'b0}});
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], src_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi  <= '0;
            acc_lo  <= '0;
            opb     <= '0;
            is_div  <= 1'b0;
            running <= 1'b0;
            cnt     <= '0;
        end else if (abort) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            acc_hi  <= nxt_hi;
            acc_lo  <= nxt_lo;
            opb     <= b;
            is_div  <= div_mode;
            running <= 1'b1;
            cnt     <= CW'(1);
        end else if (running && (cnt != CW'(WIDTH))) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + CW'(1);
        end
    end

    assign done = running && (cnt == CW'(WIDTH));
    assign hi   = acc_hi;
    assign lo   = acc_lo;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM plus single-cycle datapath.
// Define ALU_MULDIV_EN to build in the iterative mul/mulhu/divu/remu unit.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             br_taken,
    output logic             illegal
);

    state_t           state;
    logic [WIDTH-1:0] alu_res;
    logic             alu_br, alu_ill;
    logic [SHW-1:0]   shamt;

    assign shamt = a[SHW-1:0];

    // Opcodes 16-19 fall through to illegal here; with the iterative unit
    // built in they are diverted to BUSY before this result is used.
    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: alu_res = WIDTH'(a < b);
            OP_SLL:  alu_res = b << shamt;
            OP_SRL:  alu_res = b >> shamt;
            OP_SRA:  alu_res = $signed(b) >>> shamt;
            OP_BNE:  alu_br  = (a != b);
            OP_LUI:  alu_res = b << (WIDTH / 2);
            OP_BEQ:  alu_br  = (a == b);
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic             md_done, sel_hi;
    logic [WIDTH-1:0] md_hi, md_lo;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    ((state == ST_IDLE) && in_valid && !flush && is_multicycle(op)),
        .abort    (flush),
        .div_mode (op[1]),
        .a        (a),
        .b        (b),
        .done     (md_done),
        .hi       (md_hi),
        .lo       (md_lo)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            result   <= '0;
            br_taken <= 1'b0;
            illegal  <= 1'b0;
`ifdef ALU_MULDIV_EN
            sel_hi   <= 1'b0;
`endif
        end else if (flush) begin
            state    <= ST_IDLE;
            result   <= '0;
            br_taken <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
`ifdef ALU_MULDIV_EN
                        if (is_multicycle(op)) begin
                            state  <= ST_BUSY;
                            sel_hi <= op[0];
                        end else
`endif
                        begin
                            state    <= ST_DONE;
                            result   <= alu_res;
                            br_taken <= alu_br;
                            illegal  <= alu_ill;
                        end
                    end
                end
`ifdef ALU_MULDIV_EN
                ST_BUSY: begin
                    if (md_done) begin
                        state    <= ST_DONE;
                        result   <= sel_hi ? md_hi : md_lo;
                        br_taken <= 1'b0;
                        illegal  <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the Mips32 datapath. It executes the integer ALU opcode set in one cycle. Iterative unsigned multiply and divide take WIDTH cycles. Every transaction uses a valid/ready handshake on both input and output, so the pipeline can stall the block and the block can stall the pipeline. The block sits in EX, between the operand muxes and the EX/MEM register, and drives the branch-taken flag to PC select.

## Interface
- WIDTH, 32: operand and result width; even, ≥ 8.
- SHW, $clog2(WIDTH): shift-amount width (derived).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  5  opcode (codes in alu_pkg).
- a  in  WIDTH  operand A (shift amount for shifts).
- b  in  WIDTH  operand B (shifted value for shifts).
- flush  in  1  synchronous abort of the in-flight op.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  result; for mulhu/remu this is the upper word or the remainder.
- br_taken  out  1  branch condition true (beq/bne only).
- illegal  out  1  opcode undefined or compiled out.

## Operation
- Opcodes: add 0, sub 1, and 2, or 3, xor 4, nor 5, slt 6 (signed), sltu 7, sll 8, srl 9, sra 10, bne 11, lui 12, beq 13, mul 16 (low word), mulhu 17 (high word), divu 18 (quotient), remu 19 (remainder). All other codes are illegal.
- Shifts: result = b shifted by a[SHW-1:0]; sra is arithmetic on signed b.
- lui: result = b << (WIDTH/2).
- Add/sub wrap modulo 2^WIDTH; no overflow trap.
- slt/sltu: result = {WIDTH-1 zeros, cmp}.
- beq/bne: result = 0; br_taken = (a==b) or (a!=b) respectively. br_taken = 0 for all other ops.
- Illegal op: result = 0, br_taken = 0, illegal = 1. It completes as a single-cycle op.
- divu/remu with b = 0: quotient all-ones, remainder = a; the op still takes the full latency.
- FSM states:
  - IDLE → DONE when in_valid and op is single-cycle.
  - IDLE → BUSY when in_valid and op is mul/div; operands are latched.
  - BUSY counts WIDTH iterations (shift-add multiply, restoring divide), then → DONE.
  - DONE → IDLE on out_ready.
- flush: in BUSY or DONE, flush returns to IDLE next cycle with out_valid = 0 and the result discarded. In IDLE, flush blocks acceptance that cycle. flush has priority over in_valid and out_ready.

## Timing
- Reset values: in_ready = 1, out_valid = 0, result = 0, br_taken = 0, illegal = 0, state IDLE, iteration counter 0.
- Reset asserted mid-operation returns all of the above immediately; partial products are discarded.
- Single-cycle op accepted at edge N: out_valid high after edge N+1.
- Mul/div op accepted at edge N: out_valid high after edge N+WIDTH+1.
- result, br_taken and illegal are registered and stable while out_valid = 1 and out_ready = 0.
- in_ready is low in BUSY and DONE. There is no back-to-back issue: minimum throughput is 1 op per 2 cycles.
- in_ready is a function of state only; no combinational path from out_ready.

## Configuration
- ALU_MULDIV_EN defined: opcodes 16–19 are implemented as above.
- ALU_MULDIV_EN undefined: the iterative unit is not instantiated and opcodes 16–19 are treated as illegal (single-cycle, result 0, illegal = 1). The BUSY state and iteration counter are removed.

## Structure
- alu_pkg holds:
  - the opcode localparams;
  - the FSM state enum (IDLE/BUSY/DONE);
  - the function is_multicycle(op).
- The sub-module alu_muldiv_iter, parametrised by WIDTH, provides:
  - ports: start, operands, mode; done, hi/lo or quotient/remainder;
  - iteration counter and accumulator registers.

  It is instantiated under ALU_MULDIV_EN. alu_mc owns the handshake FSM and the single-cycle datapath.

## Test plan
- add a=0xFFFFFFFF, b=1 → after 1 cycle: out_valid, result=0, illegal=0; sub a=0, b=1 → 0xFFFFFFFF.
- sra a=4, b=0x80000000 → 0xF8000000. lui b=0x1234 → 0x12340000. slt a=0xFFFFFFFF, b=1 → 1; sltu on the same operands → 0.
- bne a=5, b=5 → br_taken=0; beq a=5, b=5 → br_taken=1, result=0.
- mul a=0xFFFF, b=0x10001 → out_valid at cycle 33, result=0xFFFFFFFF; mulhu a=b=0x80000000 → 0x40000000. divu 100/7 → 14, remu → 2. divu 9/0 → 0xFFFFFFFF, remu → 9.
- mul issued, out_ready held low 5 cycles → result stable, in_ready=0. Flush at iteration 10 → IDLE next cycle, out_valid never asserted. rst_n pulsed mid-BUSY → all outputs return to reset values immediately.
- op=14 → illegal=1, result=0. Rebuilt without ALU_MULDIV_EN: op=16 → illegal=1 after 1 cycle.
